// File: rtl/fb_arbiter.sv
// Frame-buffer access arbiter.
//
// Shares one single-port synchronous frame-buffer RAM between the VGA scanout
// reader and a pixel writer. Scanout reads always own the RAM slot. Writes are
// queued in a small FIFO and drained on read-free cycles. A read that hits an
// address still waiting in the FIFO returns the youngest queued data instead of
// the stale RAM word.
//
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   rd_req, rd_addr       scanout read request and address
//   rd_valid, rd_data     read result, one cycle after rd_req
//   wr_valid, wr_addr,
//   wr_data, wr_ready     writer handshake into the FIFO
//   mem_addr, mem_wdata,
//   mem_we, mem_rdata     RAM port (read data registered inside the RAM)
//   wr_count              number of queued writes
module fb_arbiter #(
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rd_req,
  input  logic [AW-1:0]                rd_addr,
  output logic                         rd_valid,
  output logic [DW-1:0]                rd_data,
  input  logic                         wr_valid,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DW-1:0]                wr_data,
  output logic                         wr_ready,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  output logic                         mem_we,
  input  logic [DW-1:0]                mem_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   wr_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  // FIFO storage, no reset needed: entries are only read below count_q.
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic          rd_valid_q;
  logic          hit_q, hit_d;
  logic [DW-1:0] fwd_q, fwd_d;

  logic push, pop;

  // Ready depends on the registered count only, so a pop this cycle does not
  // free a slot for a push in the same cycle.
  assign wr_ready = ~reset & (count_q < FullCount);
  assign push     = wr_valid & wr_ready;

  // Reads win the slot; the FIFO head is written only on read-free cycles.
  assign pop       = ~reset & ~rd_req & (count_q != '0);
  assign mem_we    = pop;
  assign mem_addr  = rd_req ? rd_addr : addr_q[head_q];
  assign mem_wdata = data_q[head_q];

  assign wr_count = count_q;
  assign rd_valid = rd_valid_q;

  // Scan oldest to youngest so the youngest matching entry wins. The entry
  // being pushed this cycle is not yet in the valid range and is excluded.
  always_comb begin
    hit_d = 1'b0;
    fwd_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == rd_addr)) begin
        hit_d = 1'b1;
        fwd_d = data_q[head_q + PW'(i)];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_valid_q) begin
      rd_data = hit_q ? fwd_q : mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= wr_addr;
      data_q[tail_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      hit_q      <= 1'b0;
      fwd_q      <= '0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        hit_q <= hit_d;
        fwd_q <= fwd_d;
      end
      if (push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] wr_count;

  fb_arbiter #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on RAM contents, shared by the RAM and the reference model.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 15'h0010) return 8'h5A;
    if (a == 15'h0200) return 8'h00;
    return a[7:0] ^ {a[14:8], 1'b1};
  endfunction

  // Frame-buffer RAM: written only by the DUT, read data registered.
  logic [DW-1:0] ram [logic [AW-1:0]];

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    mem_rdata <= ram_rd(mem_addr);
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  // Reference model: expected RAM contents plus an ordered list of pending writes.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        pend [$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic          exp_rd_valid;
  logic [DW-1:0] exp_rd_data;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input logic rst, input logic rq, input logic [AW-1:0] ra,
                       input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       output logic acc);
    logic          exp_we;
    logic          exp_ready;
    logic          nxt_valid;
    logic [DW-1:0] nxt_data;
    entry_t        e;
    reset    = rst;
    rd_req   = rq;
    rd_addr  = ra;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    #1;
    check_eq("rd_valid", rd_valid, exp_rd_valid);
    if (exp_rd_valid) check_eq("rd_data", rd_data, exp_rd_data);
    exp_we    = !rst && !rq && (pend.size() != 0);
    exp_ready = !rst && (pend.size() < DEPTH);
    check_eq("mem_we", mem_we, exp_we);
    if (exp_we) begin
      check_eq("mem_addr_wr", mem_addr, pend[0].addr);
      check_eq("mem_wdata", mem_wdata, pend[0].data);
    end
    if (rq) check_eq("mem_addr_rd", mem_addr, ra);
    check_eq("wr_ready", wr_ready, exp_ready);
    check_eq("wr_count", wr_count, pend.size());
    nxt_valid = rq && !rst;
    nxt_data  = ref_rd(ra);
    foreach (pend[i]) begin
      if (pend[i].addr == ra) nxt_data = pend[i].data;
    end
    acc = wv && exp_ready;
    @(posedge clk);
    if (rst) begin
      pend.delete();
    end else begin
      if (exp_we) begin
        ref_mem[pend[0].addr] = pend[0].data;
        void'(pend.pop_front());
      end
      if (acc) begin
        e.addr = wa;
        e.data = wd;
        pend.push_back(e);
      end
    end
    exp_rd_valid = nxt_valid;
    exp_rd_data  = nxt_data;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc;
    logic          hold;
    logic          rq, wv, rst;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    int            sent;
    int            budget;

    reset    = 1'b1;
    rd_req   = 1'b0;
    rd_addr  = '0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_rd_valid = 1'b0;
    exp_rd_data  = '0;
    check_eq("reset_wr_count", wr_count, 0);
    check_eq("reset_rd_valid", rd_valid, 0);
    check_eq("reset_rd_data", rd_data, 0);
    check_eq("reset_mem_we", mem_we, 0);
    check_eq("reset_wr_ready", wr_ready, 0);

    // Idle read of a preloaded word.
    cycle(1'b0, 1'b1, 15'h0010, 1'b0, '0, '0, acc);
    check_eq("idle_read_valid", rd_valid, 1);
    check_eq("idle_read_data", rd_data, 8'h5A);
    idle(1);

    // Drain in blanking.
    cycle(1'b0, 1'b0, '0, 1'b1, 15'h0100, 8'h11, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, 15'h0101, 8'h22, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, 15'h0102, 8'h33, acc);
    idle(3);
    check_eq("drain_count", wr_count, 0);
    check_eq("drain_ram0", ram_rd(15'h0100), 8'h11);
    check_eq("drain_ram2", ram_rd(15'h0102), 8'h33);

    // Read priority: writes starve while reads continue.
    for (int i = 0; i < 20; i++) begin
      wa = (i < 4) ? AW'(15'h0180 + i) : 15'h0184;
      wd = 8'hC0 + 8'(i);
      cycle(1'b0, 1'b1, AW'(15'h0020 + i), 1'b1, wa, wd, acc);
    end
    check_eq("starve_count", wr_count, 4);
    check_eq("starve_ready", wr_ready, 0);
    idle(4);
    check_eq("starve_drained", wr_count, 0);
    check_eq("starve_ram3", ram_rd(15'h0183), 8'hC3);
    idle(1);

    // Forwarding: youngest queued write wins, same-cycle push is not visible.
    cycle(1'b0, 1'b1, 15'h0200, 1'b1, 15'h0200, 8'hAA, acc);
    check_eq("fwd_same_cycle", rd_data, 8'h00);
    cycle(1'b0, 1'b1, 15'h0200, 1'b1, 15'h0200, 8'hBB, acc);
    check_eq("fwd_first", rd_data, 8'hAA);
    cycle(1'b0, 1'b1, 15'h0200, 1'b0, '0, '0, acc);
    check_eq("fwd_youngest", rd_data, 8'hBB);
    idle(3);
    check_eq("fwd_ram", ram_rd(15'h0200), 8'hBB);

    // Wrap-around with reads toggling every cycle.
    sent   = 0;
    budget = 0;
    wa     = AW'(15'h0300 + $urandom_range(0, 7));
    wd     = 8'($urandom);
    while ((sent < 3 * DEPTH + 1 || pend.size() != 0) && budget < 200) begin
      ra = AW'(15'h0300 + $urandom_range(0, 7));
      cycle(1'b0, 1'(budget), ra, 1'(sent < 3 * DEPTH + 1), wa, wd, acc);
      check_eq("wrap_count_bound", 32'(wr_count <= DEPTH), 1);
      if (acc) begin
        sent++;
        wa = AW'(15'h0300 + $urandom_range(0, 7));
        wd = 8'($urandom);
      end
      budget++;
    end
    check_eq("wrap_done", 32'(budget < 200), 1);
    check_eq("wrap_empty", wr_count, 0);
    for (int a = 15'h0300; a < 15'h0308; a++) begin
      check_eq("wrap_ram", ram_rd(AW'(a)), ref_rd(AW'(a)));
    end

    // Randomized traffic with occasional resets; the writer holds until accepted.
    hold = 1'b0;
    wv   = 1'b0;
    wa   = '0;
    wd   = '0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      rq  = ($urandom_range(0, 2) != 0);
      ra  = AW'(15'h0300 + $urandom_range(0, 15));
      if (!hold) begin
        wv = ($urandom_range(0, 1) == 1);
        wa = AW'(15'h0300 + $urandom_range(0, 15));
        wd = 8'($urandom);
      end
      cycle(rst, rq, ra, wv, wa, wd, acc);
      hold = wv && !acc;
    end
    idle(DEPTH + 1);
    for (int a = 15'h0300; a < 15'h0310; a++) begin
      check_eq("rand_ram", ram_rd(AW'(a)), ref_rd(AW'(a)));
    end

    // Reset mid-queue: pending writes are discarded.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 15'h0500, 1'b1, AW'(15'h0400 + i), 8'hE0 + 8'(i), acc);
    end
    check_eq("rstq_pending", wr_count, 3);
    cycle(1'b1, 1'b1, 15'h0500, 1'b0, '0, '0, acc);
    check_eq("rstq_count", wr_count, 0);
    check_eq("rstq_rd_valid", rd_valid, 0);
    idle(5);
    for (int i = 0; i < 3; i++) begin
      check_eq("rstq_ram", ram_rd(AW'(15'h0400 + i)), init_val(AW'(15'h0400 + i)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
